// File: rtl/vga_hvsync_generator_pkg.sv
// Shared VGA 640x480@60 timing constants, derived totals/sync windows and the position type.
package vga_timing_pkg;

    localparam int unsigned VGA_H_DISPLAY = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_V_DISPLAY = 480;
    localparam int unsigned VGA_V_BOTTOM  = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_TOP     = 33;

    localparam int unsigned VGA_H_TOTAL =
        VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned VGA_V_TOTAL =
        VGA_V_DISPLAY + VGA_V_BOTTOM + VGA_V_SYNC + VGA_V_TOP;

    localparam int unsigned VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
    localparam int unsigned VGA_H_SYNC_END   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC - 1;
    localparam int unsigned VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_BOTTOM;
    localparam int unsigned VGA_V_SYNC_END   = VGA_V_DISPLAY + VGA_V_BOTTOM + VGA_V_SYNC - 1;

    // Fixed 10-bit beam coordinate; totals above 1024 are not supported.
    typedef logic [9:0] pos_t;

    function automatic logic in_window(pos_t p, pos_t lo, pos_t hi);
        return (p >= lo) && (p <= hi);
    endfunction

endpackage

// File: rtl/vga_hvsync_generator_if.sv
// Raster timing bundle: syncs, visible flag and beam position.
interface vga_hvsync_generator_if;
    import vga_timing_pkg::*;

    logic hsync;
    logic vsync;
    logic display_on;
    pos_t hpos;
    pos_t vpos;

    modport master (output hsync, vsync, display_on, hpos, vpos);
    modport slave  (input  hsync, vsync, display_on, hpos, vpos);

endinterface

// File: rtl/vga_hvsync_generator.sv
// VGA raster counters with syncs registered from next-state counters (zero latency to hpos/vpos).
// Sync polarity: active-low by default, active-high when HVSYNC_POS_POLARITY_EN is defined.
module vga_hvsync_generator
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
    parameter int unsigned V_BOTTOM  = VGA_V_BOTTOM,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_TOP     = VGA_V_TOP
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vga_hvsync_generator_if.master vga
);

    localparam pos_t H_LAST   = pos_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam pos_t V_LAST   = pos_t'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
    localparam pos_t HS_START = pos_t'(H_DISPLAY + H_FRONT);
    localparam pos_t HS_END   = pos_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam pos_t VS_START = pos_t'(V_DISPLAY + V_BOTTOM);
    localparam pos_t VS_END   = pos_t'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
    localparam pos_t H_VIS    = pos_t'(H_DISPLAY);
    localparam pos_t V_VIS    = pos_t'(V_DISPLAY);

`ifdef HVSYNC_POS_POLARITY_EN
    localparam logic SYNC_ON = 1'b1;
`else
    localparam logic SYNC_ON = 1'b0;
`endif
    localparam logic SYNC_OFF = ~SYNC_ON;

    pos_t hpos_q, hpos_d;
    pos_t vpos_q, vpos_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic h_wrap;

    always_comb begin
        h_wrap = (hpos_q == H_LAST);
        hpos_d = h_wrap ? '0 : hpos_q + 1'b1;
        vpos_d = vpos_q;
        if (h_wrap) begin
            vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 1'b1;
        end
        // Decode from the next-state counters so syncs line up with the position they describe.
        hsync_d = in_window(hpos_d, HS_START, HS_END) ? SYNC_ON : SYNC_OFF;
        vsync_d = in_window(vpos_d, VS_START, VS_END) ? SYNC_ON : SYNC_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q  <= '0;
            vpos_q  <= '0;
            hsync_q <= SYNC_OFF;
            vsync_q <= SYNC_OFF;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign vga.hpos       = hpos_q;
    assign vga.vpos       = vpos_q;
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// Bench: standard-timing instance for reset/line checks, a shrunken-timing instance for whole-frame checks.
module tb_vga_hvsync_generator;

`ifdef HVSYNC_POS_POLARITY_EN
    localparam logic ACT = 1'b1;
`else
    localparam logic ACT = 1'b0;
`endif

    logic clk;
    logic rst_a;
    logic rst_b;

    vga_hvsync_generator_if ifa ();
    vga_hvsync_generator_if ifb ();

    vga_hvsync_generator dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .vga   (ifa)
    );

    vga_hvsync_generator #(
        .H_DISPLAY (16), .H_FRONT (4), .H_SYNC (8), .H_BACK (4),
        .V_DISPLAY (12), .V_BOTTOM (2), .V_SYNC (2), .V_TOP (3)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .vga   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int HD[2] = '{640, 16};
    int HF[2] = '{16, 4};
    int HS[2] = '{96, 8};
    int HT[2] = '{800, 32};
    int VD[2] = '{480, 12};
    int VB[2] = '{10, 2};
    int VS[2] = '{2, 2};
    int VT[2] = '{525, 19};

    int mh[2];
    int mv[2];
    logic [22:0] sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    int vis_cnt, hs_cnt, vs_cnt, bad_vis, hs_first, hs_last;

    function automatic logic [22:0] model_out(int w, int h, int v);
        logic hs, vs, de;
        hs = (h >= HD[w] + HF[w]) && (h <= HD[w] + HF[w] + HS[w] - 1);
        vs = (v >= VD[w] + VB[w]) && (v <= VD[w] + VB[w] + VS[w] - 1);
        de = (h < HD[w]) && (v < VD[w]);
        return {hs ? ACT : ~ACT, vs ? ACT : ~ACT, de, 10'(h), 10'(v)};
    endfunction

    function automatic logic [22:0] obs(int w);
        if (w == 0) return {ifa.hsync, ifa.vsync, ifa.display_on, ifa.hpos, ifa.vpos};
        return {ifb.hsync, ifb.vsync, ifb.display_on, ifb.hpos, ifb.vpos};
    endfunction

    task automatic check(string tag, logic [31:0] o, logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic clear_stats();
        vis_cnt = 0; hs_cnt = 0; vs_cnt = 0; bad_vis = 0; hs_first = -1; hs_last = -1;
    endtask

    task automatic model_reset(int w);
        mh[w] = 0;
        mv[w] = 0;
        sb.delete();
    endtask

    task automatic check_reset(int w, string tag);
        check(tag, 32'(obs(w)), 32'({~ACT, ~ACT, 1'b1, 10'd0, 10'd0}));
    endtask

    task automatic run(int w, int n);
        logic [22:0] o, e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            mh[w]++;
            if (mh[w] == HT[w]) begin
                mh[w] = 0;
                mv[w]++;
                if (mv[w] == VT[w]) mv[w] = 0;
            end
            sb.push_back(model_out(w, mh[w], mv[w]));
            #1;
            o = obs(w);
            e = sb.pop_front();
            check($sformatf("scan%0d(%0d,%0d)", w, mh[w], mv[w]), 32'(o), 32'(e));
            if (o[20]) vis_cnt++;
            if (o[20] && (int'(o[9:0]) >= VD[w])) bad_vis++;
            if (o[22] == ACT) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(o[19:10]);
                hs_last = int'(o[19:10]);
            end
            if (o[21] == ACT) vs_cnt++;
        end
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        model_reset(0);
        model_reset(1);
        repeat (3) @(posedge clk);
        #1;
        check_reset(0, "reset_a");
        check_reset(1, "reset_b");

        // Standard timing: first edge, display edge, hsync window, line wrap
        @(negedge clk);
        rst_a = 1'b1;
        run(0, 1);
        check("first_hpos", 32'(ifa.hpos), 32'd1);
        run(0, 638);
        check("de_at_639", 32'(ifa.display_on), 32'd1);
        run(0, 1);
        check("de_fall_640", 32'(ifa.display_on), 32'd0);
        clear_stats();
        run(0, 160);
        check("hsync_cycles", 32'(hs_cnt), 32'd96);
        check("hsync_first", 32'(hs_first), 32'd656);
        check("hsync_last", 32'(hs_last), 32'd751);
        check("line_wrap", 32'({ifa.hpos, ifa.vpos}), 32'({10'd0, 10'd1}));

        // Asynchronous mid-line reset, then restart from the origin
        run(0, 300);
        #2;
        rst_a = 1'b0;
        #1;
        check_reset(0, "async_reset_a");
        model_reset(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        run(0, 5);
        check("restart_a", 32'({ifa.hpos, ifa.vpos}), 32'({10'd5, 10'd0}));

        // Shrunken timing: whole frame statistics and frame wrap
        @(negedge clk);
        rst_b = 1'b1;
        clear_stats();
        run(1, 32 * 19);
        check("frame_wrap", 32'({ifb.hpos, ifb.vpos}), 32'd0);
        check("visible_cnt", 32'(vis_cnt), 32'(16 * 12));
        check("vsync_cycles", 32'(vs_cnt), 32'(2 * 32));
        check("hsync_frame", 32'(hs_cnt), 32'(8 * 19));
        check("de_blank_lines", 32'(bad_vis), 32'd0);

        run(1, 300);
        #2;
        rst_b = 1'b0;
        #1;
        check_reset(1, "async_reset_b");
        model_reset(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        run(1, 40);
        check("restart_b", 32'({ifb.hpos, ifb.vpos}), 32'({10'd8, 10'd1}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
